// File: rtl/uart_pkt_arbiter.sv
// Round-robin packet scheduler feeding one uart_tx: header, LSB, MSB, flags.
// Define UART_PKT_CHECKSUM_EN to append an XOR checksum byte.
module uart_pkt_arbiter #(
    parameter int         NUM_REQ     = 2,
    parameter logic [7:0] HDR_BASE    = 8'hA0,
    parameter int         ACK_TIMEOUT = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [16*NUM_REQ-1:0]  req_sample,
    input  logic [8*NUM_REQ-1:0]   req_flags,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    input  logic                   tx_busy,
    output logic [1:0]             grant_id,
    output logic                   pkt_done,
    output logic                   tx_err
);

`ifdef UART_PKT_CHECKSUM_EN
    localparam logic [2:0] LAST_IDX = 3'd4;
`else
    localparam logic [2:0] LAST_IDX = 3'd3;
`endif
    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);
    localparam logic [1:0] RR_INIT  = 2'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO} state_t;

    state_t               state_q, state_d;
    logic [1:0]           rr_ptr_q, rr_ptr_d;
    logic [2:0]           byte_idx_q, byte_idx_d;
    logic [7:0]           tmo_q, tmo_d;
    logic [1:0]           grant_id_q, grant_id_d;
    logic [NUM_REQ-1:0]   req_ack_q, req_ack_d;
    logic                 tx_start_q, tx_start_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 pkt_done_q, pkt_done_d;
    logic                 tx_err_q, tx_err_d;
    logic [15:0]          sample_q, sample_d;
    logic [7:0]           flags_q, flags_d;

    logic [3:0]           valid_ext;
    logic [63:0]          sample_ext;
    logic [31:0]          flags_ext;
    logic [1:0]           grant_sel;
    logic                 grant_found;
    logic [7:0]           hdr_byte;
    logic [7:0]           cur_byte;
    logic                 byte_complete;

    assign valid_ext  = 4'(req_valid);
    assign sample_ext = 64'(req_sample);
    assign flags_ext  = 32'(req_flags);
    assign hdr_byte   = HDR_BASE | {6'b0, grant_id_q};

    // First valid source after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_sel   = 2'd0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(rr_ptr_q) + off) % NUM_REQ;
            if (!grant_found && valid_ext[2'(idx)]) begin
                grant_found = 1'b1;
                grant_sel   = 2'(idx);
            end
        end
    end

    always_comb begin
        case (byte_idx_q)
            3'd0:    cur_byte = hdr_byte;
            3'd1:    cur_byte = sample_q[7:0];
            3'd2:    cur_byte = sample_q[15:8];
            3'd3:    cur_byte = flags_q;
`ifdef UART_PKT_CHECKSUM_EN
            default: cur_byte = hdr_byte ^ sample_q[7:0] ^ sample_q[15:8] ^ flags_q;
`else
            default: cur_byte = 8'h00;
`endif
        endcase
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        byte_idx_d    = byte_idx_q;
        tmo_d         = tmo_q;
        grant_id_d    = grant_id_q;
        req_ack_d     = '0;
        tx_start_d    = 1'b0;
        tx_data_d     = tx_data_q;
        pkt_done_d    = 1'b0;
        tx_err_d      = 1'b0;
        sample_d      = sample_q;
        flags_d       = flags_q;
        byte_complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_found && !tx_busy) begin
                    grant_id_d = grant_sel;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        req_ack_d[i] = (2'(i) == grant_sel);
                    end
                    sample_d   = sample_ext[{grant_sel, 4'b0000} +: 16];
                    flags_d    = flags_ext[{grant_sel, 3'b000} +: 8];
                    byte_idx_d = 3'd0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                tx_data_d  = cur_byte;
                tx_start_d = 1'b1;
                tmo_d      = 8'd0;
                state_d    = WAIT_HI;
            end
            WAIT_HI: begin
                if (tx_busy) begin
                    state_d = WAIT_LO;
                end else if (tmo_q == TMO_LAST) begin
                    // Transmitter never acknowledged: flag it and move on.
                    tx_err_d      = 1'b1;
                    byte_complete = 1'b1;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    byte_complete = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (byte_complete) begin
            if (byte_idx_q == LAST_IDX) begin
                pkt_done_d = 1'b1;
                rr_ptr_d   = grant_id_q;
                state_d    = IDLE;
            end else begin
                byte_idx_d = byte_idx_q + 3'd1;
                state_d    = ISSUE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= RR_INIT;
            byte_idx_q <= 3'd0;
            tmo_q      <= 8'd0;
            grant_id_q <= 2'd0;
            req_ack_q  <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            pkt_done_q <= 1'b0;
            tx_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            byte_idx_q <= byte_idx_d;
            tmo_q      <= tmo_d;
            grant_id_q <= grant_id_d;
            req_ack_q  <= req_ack_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            pkt_done_q <= pkt_done_d;
            tx_err_q   <= tx_err_d;
        end
    end

    // Payload holding registers are only read after a grant loads them.
    always_ff @(posedge clk) begin
        sample_q <= sample_d;
        flags_q  <= flags_d;
    end

    assign req_ack  = req_ack_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign grant_id = grant_id_q;
    assign pkt_done = pkt_done_q;
    assign tx_err   = tx_err_q;

endmodule
